// File: rtl/m68k_bus_target_pkg.sv
// Shared types and constants for the 68000 bus target slice.
// The timeout option is selected with the BUS_TIMEOUT_EN macro in the top level.
package m68k_bus_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;

  localparam logic [1:0] BE_UPPER = 2'b10;
  localparam logic [1:0] BE_LOWER = 2'b01;
  localparam logic [1:0] BE_WORD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    BUSY,
    WAITS,
    DONE,
    DRAIN,
    FAULT
  } bus_state_t;

  // Window compare on the byte address rebuilt from CPU address bits [23:1].
  function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                    input logic [23:0]       base,
                                    input logic [23:0]       mask);
    return (({addr, 1'b0} & mask) == (base & mask));
  endfunction

endpackage

// File: rtl/m68k_bus_target_if.sv
// CPU-side 68000 bus bundle: strobes, address, data and the acknowledge lines.
interface m68k_bus_if;
  import m68k_bus_pkg::*;

  logic              as_n;
  logic              rw_n;
  logic              uds_n;
  logic              lds_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] cpu_dout;
  logic [DATA_W-1:0] cpu_din;
  logic              dtack_n;
  logic              berr_n;

  modport master (
    output as_n, rw_n, uds_n, lds_n, addr, cpu_dout,
    input  cpu_din, dtack_n, berr_n
  );

  modport slave (
    input  as_n, rw_n, uds_n, lds_n, addr, cpu_dout,
    output cpu_din, dtack_n, berr_n
  );

endinterface

// File: rtl/m68k_bus_target_wait_counter.sv
// Loadable down-counter with a zero flag; stops at zero.
// Used for both the post-ack wait states and the optional backend timeout.
module m68k_wait_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/m68k_bus_target.sv
// Generic 68000 bus responder: decodes an address window, forwards each CPU
// cycle to a single-request/ack backend and answers with DTACKn after a
// configurable number of wait states.
// Define BUS_TIMEOUT_EN to add a backend timeout that raises BERRn.
module m68k_bus_target
  import m68k_bus_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR   = 24'h005000,
  parameter logic [23:0] ADDR_MASK   = 24'hFFF000,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              reset,
  m68k_bus_if.slave         bus,
  output logic              req,
  output logic              we,
  output logic [1:0]        be,
  output logic [ADDR_W-1:0] baddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ack
);

  localparam int unsigned CNT_MAX = (TIMEOUT > WAIT_STATES) ? TIMEOUT : WAIT_STATES;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  // Counter is loaded with N-1 and the zero flag is acted on one cycle later,
  // so N counted cycles elapse before the transition.
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    CNT_W'((WAIT_STATES == 0) ? 0 : (WAIT_STATES - 1));
`ifdef BUS_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD =
    CNT_W'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));
`endif

  bus_state_t        state;
  bus_state_t        state_next;
  logic              sel;
  logic              accept;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_dec;
  logic              cnt_zero;
  logic [DATA_W-1:0] din_q;
  logic              dtack_q;

  assign sel = !bus.as_n
            && addr_hit(bus.addr, BASE_ADDR, ADDR_MASK)
            && (!bus.uds_n || !bus.lds_n);

  assign accept = (state == IDLE) && sel;

  m68k_wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_val    = WAIT_LOAD;
    cnt_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (sel) begin
          state_next = BUSY;
`ifdef BUS_TIMEOUT_EN
          cnt_load   = 1'b1;
          cnt_val    = TIMEOUT_LOAD;
`endif
        end
      end
      BUSY: begin
`ifdef BUS_TIMEOUT_EN
        cnt_dec = !ack;
`endif
        if (ack) begin
          if (bus.as_n) begin
            state_next = IDLE;
          end else if (WAIT_STATES == 0) begin
            state_next = DONE;
          end else begin
            state_next = WAITS;
            cnt_load   = 1'b1;
            cnt_val    = WAIT_LOAD;
          end
        end else if (bus.as_n) begin
          state_next = DRAIN;
`ifdef BUS_TIMEOUT_EN
        end else if (cnt_zero) begin
          state_next = FAULT;
`endif
        end
      end
      WAITS: begin
        if (bus.as_n) begin
          state_next = IDLE;
        end else if (cnt_zero) begin
          state_next = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        if (bus.as_n) begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (ack) begin
          state_next = IDLE;
`ifdef BUS_TIMEOUT_EN
        end else if (cnt_zero) begin
          state_next = IDLE;
        end else begin
          cnt_dec = 1'b1;
`endif
        end
      end
      FAULT: begin
        if (bus.as_n) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Backend request, latched cycle attributes, read data and DTACKn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req     <= 1'b0;
      we      <= 1'b0;
      be      <= '0;
      baddr   <= '0;
      wdata   <= '0;
      din_q   <= '0;
      dtack_q <= 1'b1;
    end else begin
      req <= accept;
      if (accept) begin
        we    <= !bus.rw_n;
        be    <= {!bus.uds_n, !bus.lds_n};
        baddr <= bus.addr;
        wdata <= bus.cpu_dout;
      end
      if ((state == BUSY) && ack && !bus.as_n && !we) begin
        din_q <= rdata;
      end
      dtack_q <= !((state == DONE) && !bus.as_n);
    end
  end

  assign bus.cpu_din = din_q;
  assign bus.dtack_n = dtack_q;

`ifdef BUS_TIMEOUT_EN
  logic berr_q;

  // BERRn follows entry into and exit from FAULT on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      berr_q <= 1'b1;
    end else begin
      berr_q <= (state_next != FAULT);
    end
  end

  assign bus.berr_n = berr_q;
`else
  assign bus.berr_n = 1'b1;
`endif

endmodule

// File: tb/tb_m68k_bus_target.sv
// Scoreboard bench for m68k_bus_target: stimulus pushes expected backend
// requests, DTACKn/BERRn responses and point probes; one monitor compares.
module tb_m68k_bus_target;
  import m68k_bus_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              req;
  logic              we;
  logic [1:0]        be;
  logic [ADDR_W-1:0] baddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  always #5 clk = ~clk;

  m68k_bus_if bus ();

  m68k_bus_target #(
    .BASE_ADDR   (24'h005000),
    .ADDR_MASK   (24'hFFF000),
    .WAIT_STATES (2),
    .TIMEOUT     (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .req   (req),
    .we    (we),
    .be    (be),
    .baddr (baddr),
    .wdata (wdata),
    .rdata (rdata),
    .ack   (ack)
  );

  typedef enum int {
    SIG_DTACK, SIG_BERR, SIG_REQ, SIG_WE, SIG_BE, SIG_BADDR, SIG_WDATA,
    SIG_DIN, SIG_REQQ, SIG_DTKQ, SIG_BERRQ
  } sig_e;

  typedef struct {
    logic [1:0]  be;
    logic        we;
    logic [22:0] baddr;
    logic [15:0] wdata;
  } req_exp_t;

  typedef struct {
    logic [15:0] din;
    int          lat;
  } dtk_exp_t;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] exp;
  } probe_t;

  req_exp_t req_q[$];
  dtk_exp_t dtk_q[$];
  int       berr_q[$];
  probe_t   probe_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ack_edge = 0;
  int req_cyc  = 0;
  logic req_prev  = 1'b0;
  logic dtk_prev  = 1'b1;
  logic berr_prev = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      SIG_DTACK: return 32'(bus.dtack_n);
      SIG_BERR:  return 32'(bus.berr_n);
      SIG_REQ:   return 32'(req);
      SIG_WE:    return 32'(we);
      SIG_BE:    return 32'(be);
      SIG_BADDR: return 32'(baddr);
      SIG_WDATA: return 32'(wdata);
      SIG_DIN:   return 32'(bus.cpu_din);
      SIG_REQQ:  return 32'(req_q.size());
      SIG_DTKQ:  return 32'(dtk_q.size());
      default:   return 32'(berr_q.size());
    endcase
  endfunction

  // Monitor: evaluates probes and matches DUT events against the queues.
  always @(negedge clk) begin
    while (probe_q.size() > 0) begin
      check(probe_q[0].name, sample(probe_q[0].sig), probe_q[0].exp);
      void'(probe_q.pop_front());
    end
    if (ack) ack_edge <= cyc + 1;
    if (req_prev) check("req_pulse_width", 32'(req), 32'd0);
    if (req && !req_prev) begin
      req_cyc <= cyc;
      if (req_q.size() == 0) begin
        check("req_unexpected", 32'(req), 32'd0);
      end else begin
        check("req_be",    32'(be),    32'(req_q[0].be));
        check("req_we",    32'(we),    32'(req_q[0].we));
        check("req_baddr", 32'(baddr), 32'(req_q[0].baddr));
        check("req_wdata", 32'(wdata), 32'(req_q[0].wdata));
        void'(req_q.pop_front());
      end
    end
    if (!bus.dtack_n && dtk_prev) begin
      if (dtk_q.size() == 0) begin
        check("dtack_unexpected", 32'(bus.dtack_n), 32'd1);
      end else begin
        check("dtack_latency", 32'(cyc - ack_edge), 32'(dtk_q[0].lat));
        check("dtack_cpu_din", 32'(bus.cpu_din), 32'(dtk_q[0].din));
        void'(dtk_q.pop_front());
      end
    end
    if (!bus.berr_n && berr_prev) begin
      if (berr_q.size() == 0) begin
        check("berr_unexpected", 32'(bus.berr_n), 32'd1);
      end else begin
        check("berr_latency", 32'(cyc - req_cyc), 32'(berr_q[0]));
        void'(berr_q.pop_front());
      end
    end
    req_prev  <= req;
    dtk_prev  <= bus.dtack_n;
    berr_prev <= bus.berr_n;
  end

  task automatic probe(input string name, input sig_e sig, input logic [31:0] exp);
    probe_t p;
    p.name = name;
    p.sig  = sig;
    p.exp  = exp;
    probe_q.push_back(p);
  endtask

  task automatic exp_req(input logic [1:0] b, input logic w, input logic [22:0] a, input logic [15:0] d);
    req_exp_t e;
    e.be = b; e.we = w; e.baddr = a; e.wdata = d;
    req_q.push_back(e);
  endtask

  task automatic exp_dtack(input logic [15:0] d, input int lat);
    dtk_exp_t e;
    e.din = d; e.lat = lat;
    dtk_q.push_back(e);
  endtask

  task automatic cpu_start(input logic [23:0] a, input logic rw, input logic u, input logic l,
                           input logic [15:0] d);
    bus.addr     = a[23:1];
    bus.rw_n     = rw;
    bus.uds_n    = u;
    bus.lds_n    = l;
    bus.cpu_dout = d;
    bus.as_n     = 1'b0;
  endtask

  task automatic cpu_idle();
    bus.as_n  = 1'b1;
    bus.uds_n = 1'b1;
    bus.lds_n = 1'b1;
    bus.rw_n  = 1'b1;
  endtask

  task automatic wait_req(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (req) break;
    end
    if (i == bound) probe("req_wait", SIG_REQ, 32'd1);
  endtask

  task automatic wait_dtack(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (!bus.dtack_n) break;
    end
    if (i == bound) probe("dtack_wait", SIG_DTACK, 32'd0);
  endtask

  task automatic ack_after(input int gap, input logic [15:0] d);
    repeat (gap) @(posedge clk);
    #1 ack = 1'b1; rdata = d;
    @(posedge clk);
    #1 ack = 1'b0; rdata = '0;
  endtask

  task automatic read_cycle(input logic [23:0] a, input logic [15:0] d);
    exp_req(BE_WORD, 1'b0, a[23:1], 16'h0000);
    exp_dtack(d, 3);
    cpu_start(a, 1'b1, 1'b0, 1'b0, 16'h0000);
    wait_req(20);
    ack_after(2, d);
    wait_dtack(20);
    cpu_idle();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ack   = 1'b0;
    rdata = '0;
    bus.addr = '0;
    bus.cpu_dout = '0;
    cpu_idle();
    repeat (3) @(posedge clk);
    #1;
    probe("rst_dtack", SIG_DTACK, 32'd1);
    probe("rst_berr",  SIG_BERR,  32'd1);
    probe("rst_req",   SIG_REQ,   32'd0);
    probe("rst_we",    SIG_WE,    32'd0);
    probe("rst_be",    SIG_BE,    32'd0);
    probe("rst_din",   SIG_DIN,   32'd0);
    probe("rst_baddr", SIG_BADDR, 32'd0);
    probe("rst_wdata", SIG_WDATA, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // Word read, backend acks 3 cycles after req.
    exp_req(BE_WORD, 1'b0, 23'h002800, 16'hA5A5);
    exp_dtack(16'hBEEF, 3);
    cpu_start(24'h005000, 1'b1, 1'b0, 1'b0, 16'hA5A5);
    wait_req(20);
    ack_after(2, 16'hBEEF);
    wait_dtack(20);
    repeat (2) @(posedge clk);
    #1 probe("dtack_held", SIG_DTACK, 32'd0);
    cpu_idle();
    @(posedge clk); #1;
    probe("dtack_release", SIG_DTACK, 32'd1);
    probe("din_after_read", SIG_DIN, 32'h0000BEEF);
    @(posedge clk); #1;

    // Byte write to the upper lane; read data on ack must not be captured.
    exp_req(BE_UPPER, 1'b1, 23'h002802, 16'h12AB);
    exp_dtack(16'hBEEF, 3);
    cpu_start(24'h005004, 1'b0, 1'b0, 1'b1, 16'h12AB);
    wait_req(20);
    ack_after(1, 16'hDEAD);
    wait_dtack(20);
    cpu_idle();
    @(posedge clk); #1;
    probe("din_after_write", SIG_DIN, 32'h0000BEEF);
    probe("we_held", SIG_WE, 32'd1);
    @(posedge clk); #1;

    // Outside the window: no request, no acknowledge.
    cpu_start(24'h006000, 1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (12) begin
      @(posedge clk); #1;
      probe("outside_dtack", SIG_DTACK, 32'd1);
      probe("outside_req", SIG_REQ, 32'd0);
    end
    cpu_idle();
    @(posedge clk); #1;

    // Abort one cycle after req, late ack drained, then a normal read.
    exp_req(BE_WORD, 1'b0, 23'h002808, 16'h0000);
    cpu_start(24'h005010, 1'b1, 1'b0, 1'b0, 16'h0000);
    wait_req(20);
    @(posedge clk); #1 cpu_idle();
    ack_after(4, 16'h5555);
    repeat (6) begin
      @(posedge clk); #1;
      probe("abort_dtack", SIG_DTACK, 32'd1);
    end
    probe("abort_din", SIG_DIN, 32'h0000BEEF);
    read_cycle(24'h005020, 16'hCAFE);

    // Reset while counting wait states, then a normal read.
    exp_req(BE_WORD, 1'b0, 23'h002818, 16'h0000);
    cpu_start(24'h005030, 1'b1, 1'b0, 1'b0, 16'h0000);
    wait_req(20);
    ack_after(1, 16'h7777);
    reset = 1'b1;
    cpu_idle();
    probe("midrst_dtack", SIG_DTACK, 32'd1);
    probe("midrst_din",   SIG_DIN,   32'd0);
    probe("midrst_req",   SIG_REQ,   32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    read_cycle(24'h005040, 16'h1357);

`ifdef BUS_TIMEOUT_EN
    // Backend never acks: BERRn after TIMEOUT cycles, late ack ignored.
    begin
      int k;
      exp_req(BE_WORD, 1'b0, 23'h002828, 16'h0000);
      berr_q.push_back(64);
      cpu_start(24'h005050, 1'b1, 1'b0, 1'b0, 16'h0000);
      wait_req(20);
      for (k = 0; k < 100; k++) begin
        @(posedge clk); #1;
        if (!bus.berr_n) break;
      end
      if (k == 100) probe("berr_wait", SIG_BERR, 32'd0);
      repeat (4) begin
        @(posedge clk); #1;
        probe("berr_held", SIG_BERR, 32'd0);
        probe("berr_dtack", SIG_DTACK, 32'd1);
      end
      cpu_idle();
      @(posedge clk); #1;
      probe("berr_release", SIG_BERR, 32'd1);
      ack_after(0, 16'h9999);
      repeat (5) begin
        @(posedge clk); #1;
        probe("late_ack_dtack", SIG_DTACK, 32'd1);
      end
    end
`endif

    @(posedge clk); #1;
    probe("req_queue_empty",   SIG_REQQ,  32'd0);
    probe("dtack_queue_empty", SIG_DTKQ,  32'd0);
    probe("berr_queue_empty",  SIG_BERRQ, 32'd0);
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
